// File: rtl/ibex_fp_wb_ctrl.sv
// FP register file write-side controller: LSU/FPU write-port arbitration, pending scoreboard, RAW/WAW checks.
// Optional operand bypass from the write port is enabled by defining IBEX_FP_WB_BYPASS_EN.
module ibex_fp_wb_ctrl #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  input  logic                 issue_wb_i,
  input  logic [4:0]           issue_rd_i,
  output logic                 issue_ready_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [4:0]           raddr_c_i,
  input  logic                 ruse_a_i,
  input  logic                 ruse_b_i,
  input  logic                 ruse_c_i,
  output logic                 hazard_o,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic                 fwd_c_o,
  input  logic                 fpu_valid_i,
  input  logic [4:0]           fpu_rd_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  output logic                 fpu_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_rd_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic [31:0]          pending_o
);

  logic [31:0] pending_q, pending_d;
  logic        accept;
  logic        issue_hs;
  logic        bypass_a, bypass_b, bypass_c;

  // Loads cannot be stalled, so the FPU only gets the port when no load is present.
  assign fpu_ready_o = ~lsu_valid_i;
  assign accept      = lsu_valid_i | (fpu_valid_i & fpu_ready_o);

  // WAW stall holds even while the pending write sits on the port this cycle.
  assign issue_ready_o = ~(issue_wb_i & pending_q[issue_rd_i]);
  assign issue_hs      = issue_valid_i & issue_ready_o & issue_wb_i;

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= accept;
      if (accept) begin
        rf_waddr_o <= lsu_valid_i ? lsu_rd_i    : fpu_rd_i;
        rf_wdata_o <= lsu_valid_i ? lsu_wdata_i : fpu_wdata_i;
      end
    end
  end

  // NOTE: default assignment first in always_comb so no path leaves pending_d unassigned (no latch).
  always_comb begin
    pending_d = pending_q;
    if (rf_we_o) pending_d[rf_waddr_o] = 1'b0;
    // Applied after the clear so a same-edge set wins.
    if (issue_hs) pending_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  assign pending_o = pending_q;

`ifdef IBEX_FP_WB_BYPASS_EN
  assign bypass_a = rf_we_o & (rf_waddr_o == raddr_a_i) & ruse_a_i;
  assign bypass_b = rf_we_o & (rf_waddr_o == raddr_b_i) & ruse_b_i;
  assign bypass_c = rf_we_o & (rf_waddr_o == raddr_c_i) & ruse_c_i;
`else
  assign bypass_a = 1'b0;
  assign bypass_b = 1'b0;
  assign bypass_c = 1'b0;
`endif

  assign fwd_a_o = bypass_a;
  assign fwd_b_o = bypass_b;
  assign fwd_c_o = bypass_c;

  assign hazard_o = (ruse_a_i & pending_q[raddr_a_i] & ~bypass_a) |
                    (ruse_b_i & pending_q[raddr_b_i] & ~bypass_b) |
                    (ruse_c_i & pending_q[raddr_c_i] & ~bypass_c);

endmodule

// File: doc/ibex_fp_wb_ctrl.md
# ibex_fp_wb_ctrl

Write-side controller for the 32-entry floating-point register file. Takes results from the FPU (backpressured) and the LSU FP loads (never stalled), arbitrates them onto the register file's single write port, and keeps a 32-bit pending scoreboard. The scoreboard drives RAW hazard detection for the three operand read ports and WAW stalls at issue. It sits between the FP issue/decode stage, the FPU and LSU result buses, and the register file write port.

## Interface
- DataWidth, 32, FP register and result data width

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  instruction presented for issue
- issue_wb_i  in  1  issuing instruction writes an FP register
- issue_rd_i  in  5  FP destination register
- issue_ready_o  out  1  issue accepted this cycle
- raddr_a_i / raddr_b_i / raddr_c_i  in  5 each  operand register addresses
- ruse_a_i / ruse_b_i / ruse_c_i  in  1 each  operand actually used
- hazard_o  out  1  a used operand is pending (RAW stall)
- fwd_a_o / fwd_b_o / fwd_c_o  out  1 each  operand should take rf_wdata_o (bypass)
- fpu_valid_i  in  1  FPU result valid
- fpu_rd_i  in  5  FPU destination
- fpu_wdata_i  in  DataWidth  FPU result
- fpu_ready_o  out  1  FPU result accepted
- lsu_valid_i  in  1  FP load data valid (always accepted)
- lsu_rd_i  in  5  load destination
- lsu_wdata_i  in  DataWidth  load data
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data
- pending_o  out  32  scoreboard state

## Operation
- Arbitration: LSU has fixed priority. fpu_ready_o = !lsu_valid_i. A result is accepted when lsu_valid_i is high, or when fpu_valid_i && fpu_ready_o.
- Write stage: one output register. An accepted result is loaded into rf_we_o/rf_waddr_o/rf_wdata_o at the next edge. When nothing is accepted, rf_we_o is 0 for that cycle and rf_waddr_o/rf_wdata_o hold their values.
- Scoreboard pending[31:0]:
  - Set bit issue_rd_i on an issue handshake (issue_valid_i && issue_ready_o && issue_wb_i).
  - Clear bit rf_waddr_o on the edge that ends a cycle with rf_we_o high.
  - If set and clear hit the same bit on the same edge, set wins.
- issue_ready_o = !(issue_wb_i && pending[issue_rd_i]). This is a WAW stall, and it applies even if that register's write is on the port this cycle.
- hazard_o is the OR, over ports a/b/c, of ruse_x && pending[raddr_x] && !bypass_x.
- A result whose register is not pending is still written, and the scoreboard is unchanged. This is legal, not an error.
- All 32 registers, including f0, are writable and tracked.
- A LSU result and a FPU result targeting the same rd in the same cycle: the LSU result is written, and the FPU result waits.

## Timing
- Reset: pending_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0. With pending 0, issue_ready_o=1 and hazard_o=0. fwd_*_o=0.
- Result accepted in cycle N: rf_we_o=1 in cycle N+1. The pending bit reads 0 from cycle N+2.
- Issue handshake in cycle N: the pending bit reads 1 from cycle N+1.
- hazard_o, issue_ready_o, fpu_ready_o and fwd_*_o are combinational. No cycle of input-to-output latency.
- Reset asserted mid-operation clears the scoreboard and any in-flight write immediately. The write is lost and rf_we_o drops asynchronously.

## Configuration
- IBEX_FP_WB_BYPASS_EN defined: bypass_x = rf_we_o && (rf_waddr_o == raddr_x) && ruse_x. fwd_x_o = bypass_x. A read of a register being written this cycle does not raise hazard_o, and the consumer uses rf_wdata_o for that operand.
- Not defined: bypass_x = 0 and fwd_*_o are tied 0. A read of a register being written stalls one extra cycle, until the pending bit clears.

## Test plan
- Reset release -> pending_o=0, rf_we_o=0, issue_ready_o=1, hazard_o=0, fpu_ready_o=1.
- Issue rd=5 in cycle 0; FPU result rd=5 with data 0x3F800000 in cycle 3 -> pending_o[5]=1 during cycles 1-4; rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x3F800000 in cycle 4; pending_o[5]=0 in cycle 5.
- lsu_valid_i and fpu_valid_i both high for one cycle, rd=7 and rd=9 -> fpu_ready_o=0; the rd=7 write happens first. With FPU held valid, the rd=9 write lands one cycle later.
- pending[3]=1 and raddr_b_i=3 with ruse_b_i=1 -> hazard_o=1. Also issue_wb_i=1 with issue_rd_i=3 -> issue_ready_o=0 until the bit clears.
- Write of rd=3 on the port with ruse_a_i=1 and raddr_a_i=3 -> with the macro: hazard_o=0, fwd_a_o=1. Without the macro: hazard_o=1, fwd_a_o=0.
- Issue rd=12 on the same edge as a spurious write to rd=12 clears it, then rst_ni pulsed low mid-write -> pending_o[12]=1 after the edge (set wins). After reset: pending_o=0 and rf_we_o=0 immediately.
